// File: rtl/pkg_link_writer_pkg.sv
// Shared types and widths for the linked-list packet memory write side.
// The writer, its pop gate and the future reader/descriptor FIFO all import this.
// Holds the FSM encoding, default widths and small width-derivation helpers.
package pkg_link_writer_pkg;

  // Writer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_NEXT  = 2'd2,
    ST_DESC  = 2'd3
  } state_t;

  // Default geometry: 16 pages of 16 words, 16-bit words
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_PAGE_LOG   = 4;
  localparam int DEF_DATA_WIDTH = 16;

  // Descriptor field widths (head/tail page, word count 1..2^ADDR_WIDTH)
  localparam int DESC_PAGE_W = DEF_PAGE_LOG;
  localparam int DESC_LEN_W  = DEF_ADDR_WIDTH + 1;

  // Statistics counter width
  localparam int STAT_W = 16;

  // Word offset inside a page is whatever address bits the page index leaves
  function automatic int offset_width(input int addr_w, input int page_w);
    return addr_w - page_w;
  endfunction

  // Counter width able to hold the value pop_gap
  function automatic int gap_width(input int pop_gap);
    return (pop_gap < 1) ? 1 : $clog2(pop_gap + 1);
  endfunction

endpackage

// File: rtl/pkg_link_writer_if.sv
// Bus bundle between the packet writer and its environment.
// slave: the writer's view; master: the environment driving words, free table, descriptor sink.
// Carries the word stream, free-table pop port, data/link RAM write ports and descriptor.
interface pkg_link_writer_if
  import pkg_link_writer_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int ADDR_PAGE_NUM_LOG = DEF_PAGE_LOG,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) ();

  logic                         pkt_valid;
  logic                         pkt_ready;
  logic [DATA_WIDTH-1:0]        pkt_data;
  logic                         pkt_last;

  logic                         free_read_req;
  logic [ADDR_PAGE_NUM_LOG-1:0] free_read_addr;
  logic                         free_empty;

  logic                         ram_write_en;
  logic [ADDR_WIDTH-1:0]        ram_write_addr;
  logic [DATA_WIDTH-1:0]        ram_write_data;

  logic                         link_write_en;
  logic [ADDR_PAGE_NUM_LOG-1:0] link_write_addr;
  logic [ADDR_PAGE_NUM_LOG-1:0] link_write_data;

  logic                         desc_valid;
  logic                         desc_ready;
  logic [ADDR_PAGE_NUM_LOG-1:0] desc_head;
  logic [ADDR_PAGE_NUM_LOG-1:0] desc_tail;
  logic [ADDR_WIDTH:0]          desc_len;

  modport slave (
    input  pkt_valid, pkt_data, pkt_last, free_read_addr, free_empty, desc_ready,
    output pkt_ready, free_read_req, ram_write_en, ram_write_addr, ram_write_data,
           link_write_en, link_write_addr, link_write_data,
           desc_valid, desc_head, desc_tail, desc_len
  );

  modport master (
    output pkt_valid, pkt_data, pkt_last, free_read_addr, free_empty, desc_ready,
    input  pkt_ready, free_read_req, ram_write_en, ram_write_addr, ram_write_data,
           link_write_en, link_write_addr, link_write_data,
           desc_valid, desc_head, desc_tail, desc_len
  );

endinterface

// File: rtl/pkg_link_writer_pop_gate.sv
// Pop gate: decides when the free-page table head may be popped.
// Latency: pop_ok is combinational; after a pop it stays low for POP_GAP cycles.
// Backpressure: pop_ok is low while the table is empty or the gap is still running.
module pkg_link_pop_gate
  import pkg_link_writer_pkg::*;
#(
  parameter int POP_GAP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pop,
  input  logic free_empty,
  output logic pop_ok
);

  localparam int GW = gap_width(POP_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POP_GAP);

  logic [GW-1:0] gap;

  // Reload on every pop, then count down to zero while the table settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= '0;
    end else if (pop) begin
      gap <= GAP_LOAD;
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

  assign pop_ok = (gap == '0) && !free_empty;

endmodule

// File: rtl/pkg_link_writer.sv
// Packet writer: pops free pages, writes words to data RAM, chains pages in link RAM, emits a descriptor.
// Latency: RAM write in the handshake cycle; descriptor valid the cycle after the last word.
// Backpressure: pkt_ready drops at each page crossing, while no page can be popped, and until the descriptor is taken.
// Optional statistics counters are built when PKG_LINK_WRITER_STAT_EN is defined.
module pkg_link_writer
  import pkg_link_writer_pkg::*;
#(
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int ADDR_PAGE_NUM_LOG = DEF_PAGE_LOG,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int POP_GAP           = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  pkg_link_writer_if.slave    bus
`ifdef PKG_LINK_WRITER_STAT_EN
  ,
  input  logic                stat_clr,
  output logic [STAT_W-1:0]   stat_pkt_cnt,
  output logic [STAT_W-1:0]   stat_stall_cnt
`endif
);

  localparam int OW = offset_width(ADDR_WIDTH, ADDR_PAGE_NUM_LOG);
  localparam int LW = ADDR_WIDTH + 1;

  state_t                       state;
  logic                         run;
  logic [ADDR_PAGE_NUM_LOG-1:0] cur_page;
  logic [ADDR_PAGE_NUM_LOG-1:0] head;
  logic [ADDR_PAGE_NUM_LOG-1:0] tail;
  logic [OW-1:0]                offset;
  logic [LW-1:0]                len;
  logic                         ready_q;
  logic                         desc_vld_q;

  logic                         pop_ok;
  logic                         pop;
  logic                         hs;
  logic                         link_en;

  // run keeps IDLE from popping while reset is asserted (pkt_valid may already be high)
  assign hs      = bus.pkt_valid && ready_q;
  assign pop     = pop_ok && (((state == ST_IDLE) && run && bus.pkt_valid) || (state == ST_NEXT));
  assign link_en = pop && (state == ST_NEXT);

  pkg_link_pop_gate #(.POP_GAP(POP_GAP)) u_pop_gate (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop        (pop),
    .free_empty (bus.free_empty),
    .pop_ok     (pop_ok)
  );

  assign bus.pkt_ready       = ready_q;
  assign bus.free_read_req   = pop;
  assign bus.ram_write_en    = hs;
  assign bus.ram_write_addr  = {cur_page, offset};
  assign bus.ram_write_data  = hs ? bus.pkt_data : '0;
  assign bus.link_write_en   = link_en;
  assign bus.link_write_addr = link_en ? cur_page : '0;
  assign bus.link_write_data = link_en ? bus.free_read_addr : '0;
  assign bus.desc_valid      = desc_vld_q;
  assign bus.desc_head       = head;
  assign bus.desc_tail       = tail;
  assign bus.desc_len        = len;

  // Main FSM: page allocation, word placement and descriptor hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      run        <= 1'b0;
      cur_page   <= '0;
      head       <= '0;
      tail       <= '0;
      offset     <= '0;
      len        <= '0;
      ready_q    <= 1'b0;
      desc_vld_q <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            head     <= bus.free_read_addr;
            cur_page <= bus.free_read_addr;
            offset   <= '0;
            len      <= '0;
            ready_q  <= 1'b1;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (hs) begin
            len    <= len + LW'(1);
            offset <= offset + OW'(1);
            // Last word wins over page-full: an exactly full final page pops nothing
            if (bus.pkt_last) begin
              tail       <= cur_page;
              ready_q    <= 1'b0;
              desc_vld_q <= 1'b1;
              state      <= ST_DESC;
            end else if (offset == '1) begin
              ready_q <= 1'b0;
              state   <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (pop) begin
            cur_page <= bus.free_read_addr;
            ready_q  <= 1'b1;
            state    <= ST_WRITE;
          end
        end
        ST_DESC: begin
          if (bus.desc_ready) begin
            desc_vld_q <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PKG_LINK_WRITER_STAT_EN
  // Saturating packet and free-table-stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else if (stat_clr) begin
      stat_pkt_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (desc_vld_q && bus.desc_ready && (stat_pkt_cnt != '1)) begin
        stat_pkt_cnt <= stat_pkt_cnt + STAT_W'(1);
      end
      if (((state == ST_IDLE) || (state == ST_NEXT)) && bus.pkt_valid && bus.free_empty &&
          (stat_stall_cnt != '1)) begin
        stat_stall_cnt <= stat_stall_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pkg_link_writer.sv
// Bench for pkg_link_writer: the bench plays free-page table, word source and descriptor sink.
// Expected placement comes from the page list: word i lands at page[i/16]*16 + i%16.
module tb_pkg_link_writer;

  localparam int AW = 8;
  localparam int PW = 4;
  localparam int DW = 16;
  localparam int GAP = 2;
  localparam int PG_WORDS = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkg_link_writer_if #(.ADDR_WIDTH(AW), .ADDR_PAGE_NUM_LOG(PW), .DATA_WIDTH(DW)) bus ();

`ifdef PKG_LINK_WRITER_STAT_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_pkt_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  pkg_link_writer #(
    .ADDR_WIDTH(AW), .ADDR_PAGE_NUM_LOG(PW), .DATA_WIDTH(DW), .POP_GAP(GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PKG_LINK_WRITER_STAT_EN
    ,
    .stat_clr       (stat_clr),
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int free_q[$];
  int pending[$];
  int pops[$];
  int wr_addr[$];
  int wr_data[$];
  int lk_from[$];
  int lk_to[$];
  bit hs_now;
  bit desc_hs_now;
  int d_head, d_tail, d_len;
  int proto_err, bubbles, ready_hi, hs_cnt, cur_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_free();
    bus.free_empty     = (free_q.size() == 0);
    bus.free_read_addr = (free_q.size() == 0) ? '0 : PW'(free_q[0]);
  endtask

  task automatic init_free(input bit shuffle);
    free_q.delete();
    pending.delete();
    for (int i = 0; i < 16; i++) free_q.push_back(i);
    if (shuffle) begin
      for (int i = 15; i > 0; i--) begin
        int j;
        int t;
        j = int'($urandom_range(i, 0));
        t = free_q[i];
        free_q[i] = free_q[j];
        free_q[j] = t;
      end
    end
    drive_free();
  endtask

  // One clock: observe strobes mid-cycle, let the edge pass, update the free table
  task automatic cycle();
    bit popped;
    #1;
    popped = 1'b0;
    hs_now = bus.pkt_valid && bus.pkt_ready;
    desc_hs_now = bus.desc_valid && bus.desc_ready;
    if (bus.ram_write_en !== hs_now) proto_err++;
    if (bus.pkt_ready && bus.free_read_req) proto_err++;
    if (bus.link_write_en && !bus.free_read_req) proto_err++;
    if (bus.desc_valid && (bus.pkt_ready || bus.free_read_req)) proto_err++;
    if (hs_now) begin
      wr_addr.push_back(int'(bus.ram_write_addr));
      wr_data.push_back(int'(bus.ram_write_data));
      hs_cnt++;
    end
    if (bus.pkt_ready) ready_hi++;
    if (hs_cnt > 0 && hs_cnt < cur_n && !bus.pkt_ready) bubbles++;
    if (bus.link_write_en) begin
      lk_from.push_back(int'(bus.link_write_addr));
      lk_to.push_back(int'(bus.link_write_data));
    end
    if (bus.free_read_req) begin
      if (free_q.size() == 0) proto_err++;
      else begin
        pops.push_back(free_q[0]);
        popped = 1'b1;
      end
    end
    if (desc_hs_now) begin
      d_head = int'(bus.desc_head);
      d_tail = int'(bus.desc_tail);
      d_len  = int'(bus.desc_len);
    end
    @(posedge clk);
    #1;
    if (popped) void'(free_q.pop_front());
    drive_free();
    cyc++;
    @(negedge clk);
  endtask

  // Send one n-word packet and compare everything it produced against the page list
  task automatic run_pkt(input int n, input bit gaps, input int hold, input bit eager);
    int words[$];
    int exp_pg[$];
    int k, idx, budget, bad, dv_cyc, last_cyc, held, stall_empty, unstable;
    int cap_h, cap_t, cap_l;
    bit done, no_release;
    k = (n + PG_WORDS - 1) / PG_WORDS;
    no_release = (pending.size() == 0);
    foreach (free_q[i]) exp_pg.push_back(free_q[i]);
    foreach (pending[i]) exp_pg.push_back(pending[i]);
    for (int i = 0; i < n; i++) words.push_back(int'($urandom_range(16'hFFFF, 0)));
    pops.delete(); wr_addr.delete(); wr_data.delete(); lk_from.delete(); lk_to.delete();
    proto_err = 0; bubbles = 0; ready_hi = 0; hs_cnt = 0; cur_n = n;
    d_head = -1; d_tail = -1; d_len = -1;
    idx = 0; done = 1'b0; budget = 1500; dv_cyc = -1; last_cyc = -1; held = 0;
    stall_empty = 0; unstable = 0; cap_h = 0; cap_t = 0; cap_l = 0;
    while (!done && budget > 0) begin
      if (free_q.size() == 0 && pending.size() != 0) begin
        stall_empty++;
        if (stall_empty >= 5) begin
          while (pending.size() != 0) free_q.push_back(pending.pop_front());
          drive_free();
        end
      end
      if (idx < n) begin
        bus.pkt_valid = !gaps || ($urandom_range(3, 0) != 0);
        bus.pkt_data  = DW'(words[idx]);
        bus.pkt_last  = (idx == n - 1);
      end else begin
        bus.pkt_valid = eager;
        bus.pkt_data  = DW'($urandom);
        bus.pkt_last  = 1'b0;
      end
      if (bus.desc_valid) begin
        if (dv_cyc < 0) begin
          dv_cyc = cyc;
          cap_h = int'(bus.desc_head); cap_t = int'(bus.desc_tail); cap_l = int'(bus.desc_len);
        end else if (cap_h != int'(bus.desc_head) || cap_t != int'(bus.desc_tail) ||
                     cap_l != int'(bus.desc_len)) begin
          unstable++;
        end
        bus.desc_ready = (held >= hold);
        held++;
      end else begin
        bus.desc_ready = (hold == 0);
      end
      cycle();
      if (hs_now) begin
        if (idx == n - 1) last_cyc = cyc - 1;
        idx++;
      end
      if (desc_hs_now) done = 1'b1;
      budget--;
    end
    bus.pkt_valid = 1'b0;
    bus.pkt_last  = 1'b0;
    bus.desc_ready = 1'b0;

    chk("desc_done", 32'(done), 32'd1);
    chk("pop_cnt", pops.size(), k);
    bad = 0;
    for (int j = 0; j < pops.size() && j < k; j++) if (pops[j] != exp_pg[j]) bad++;
    chk("pop_order", bad, 0);
    chk("wr_cnt", wr_addr.size(), n);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < n; i++)
      if (wr_addr[i] != exp_pg[i / PG_WORDS] * PG_WORDS + i % PG_WORDS || wr_data[i] != words[i]) bad++;
    chk("wr_addr_data", bad, 0);
    chk("link_cnt", lk_from.size(), k - 1);
    bad = 0;
    for (int j = 0; j < lk_from.size() && j < k - 1; j++)
      if (lk_from[j] != exp_pg[j] || lk_to[j] != exp_pg[j + 1]) bad++;
    chk("link_pairs", bad, 0);
    chk("desc_head", d_head, exp_pg[0]);
    chk("desc_tail", d_tail, exp_pg[k - 1]);
    chk("desc_len", d_len, n);
    chk("desc_rise", dv_cyc - last_cyc, 1);
    chk("desc_stable", unstable, 0);
    chk("strobe_proto", proto_err, 0);
    if (!gaps) chk("ready_cycles", ready_hi, n);
    if (!gaps && no_release) chk("page_bubbles", bubbles, k - 1);
  endtask

  initial begin
    int cnt, budget;
    rst_n = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.pkt_data = 16'hA5A5;
    bus.pkt_last = 1'b0;
    bus.desc_ready = 1'b1;
    init_free(1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_free_req", 32'(bus.free_read_req), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_write_en), 32'd0);
    chk("rst_wr_data", 32'(bus.ram_write_data), 32'd0);
    chk("rst_ready", 32'(bus.pkt_ready), 32'd0);
    chk("rst_desc_valid", 32'(bus.desc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.desc_ready = 1'b0;
    cur_n = 100;
    repeat (2) cycle();
    #1;
    chk("idle_ready", 32'(bus.pkt_ready), 32'd0);
    chk("idle_free_req", 32'(bus.free_read_req), 32'd0);
    chk("idle_desc_len", 32'(bus.desc_len), 32'd0);
    @(negedge clk);

    // Directed packets: 5 words, exactly one page, three pages
    init_free(1'b0); run_pkt(5, 1'b0, 0, 1'b0);
    init_free(1'b0); run_pkt(16, 1'b0, 0, 1'b0);
    init_free(1'b0); run_pkt(40, 1'b0, 0, 1'b0);

    // One free page left; page 7 released while the writer waits at the crossing
    free_q.delete(); pending.delete();
    free_q.push_back(3); pending.push_back(7);
    drive_free();
    run_pkt(20, 1'b0, 0, 1'b0);

    // Descriptor held off 10 cycles with the next packet already waiting
    init_free(1'b0); run_pkt(7, 1'b0, 10, 1'b1);
    run_pkt(3, 1'b0, 0, 1'b0);

    // Random lengths, source gaps and sink holds over shuffled free tables
    repeat (10) begin
      init_free(1'b1);
      run_pkt(int'($urandom_range(60, 1)), 1'($urandom_range(1, 0)),
              int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset during the third word of a packet
    init_free(1'b0);
    cur_n = 100;
    bus.pkt_valid = 1'b1;
    bus.pkt_last = 1'b0;
    bus.desc_ready = 1'b1;
    cnt = 0;
    budget = 50;
    while (cnt < 2 && budget > 0) begin
      bus.pkt_data = DW'($urandom);
      cycle();
      if (hs_now) cnt++;
      budget--;
    end
    chk("pre_reset_words", cnt, 2);
    bus.pkt_data = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(bus.ram_write_en), 32'd0);
    chk("arst_wr_addr", 32'(bus.ram_write_addr), 32'd0);
    chk("arst_wr_data", 32'(bus.ram_write_data), 32'd0);
    chk("arst_ready", 32'(bus.pkt_ready), 32'd0);
    chk("arst_free_req", 32'(bus.free_read_req), 32'd0);
    chk("arst_link_en", 32'(bus.link_write_en), 32'd0);
    chk("arst_desc_valid", 32'(bus.desc_valid), 32'd0);
    chk("arst_desc_len", 32'(bus.desc_len), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.desc_ready = 1'b0;
    init_free(1'b0);
    run_pkt(6, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
